// File: rtl/iq_monitor_switch.sv
// Selects one of N_CH packed {Q,I} monitor channels for the debug/ILA port, with output decimation.
// Latency: 1 clk from ch_valid/ch_data to out_valid/Out_q/Out_i; a select change blanks for BLANK_CYC+ cycles.
// Backpressure: none; the capture side must accept every out_valid strobe, and decim thins the rate for slow paths.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   ch_data, ch_valid    - packed channels (k at [k*2*IQ_W +: 2*IQ_W], Q upper, I lower) and their strobes
//   sel_ch, decim        - requested channel; keep 1 of every (decim+1) valid samples
//   Out_q, Out_i         - registered selected sample (zero while blanking or out of range)
//   out_valid            - one-cycle strobe per emitted sample
//   sel_active           - channel currently passed
//   switching            - high while blanking after a select change
module iq_monitor_switch #(
    parameter int N_CH      = 17,
    parameter int IQ_W      = 16,
    parameter int SEL_W     = 8,
    parameter int BLANK_CYC = 4,
    parameter int DECIM_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*2*IQ_W-1:0]   ch_data,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic [SEL_W-1:0]         sel_ch,
    input  logic [DECIM_W-1:0]       decim,
    output logic [IQ_W-1:0]          Out_q,
    output logic [IQ_W-1:0]          Out_i,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         sel_active,
    output logic                     switching
);

    localparam int DW    = 2 * IQ_W;
    localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     sel_pend, sel_pend_nxt;
    logic [SEL_W-1:0]     sel_active_nxt;
    logic [CNT_W-1:0]     blank_cnt, blank_cnt_nxt;
    logic [DECIM_W-1:0]   decim_cnt, decim_cnt_nxt;
    logic [IQ_W-1:0]      out_q_nxt, out_i_nxt;
    logic                 out_valid_nxt;
    logic                 switching_nxt;

    // Channel mux on the registered active select; sel_hit low means the
    // active select points past the last channel.
    logic [DW-1:0]        sel_word;
    logic                 sel_vld;
    logic                 sel_hit;

    always_comb begin
        sel_word = '0;
        sel_vld  = 1'b0;
        sel_hit  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_active == SEL_W'(k)) begin
                sel_word = ch_data[k*DW +: DW];
                sel_vld  = ch_valid[k];
                sel_hit  = 1'b1;
            end
        end
    end

    // State register together with the datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            sel_pend   <= '0;
            sel_active <= '0;
            blank_cnt  <= BLANK_LAST;
            decim_cnt  <= '0;
            Out_q      <= '0;
            Out_i      <= '0;
            out_valid  <= 1'b0;
            switching  <= 1'b1;
        end else begin
            state      <= state_nxt;
            sel_pend   <= sel_pend_nxt;
            sel_active <= sel_active_nxt;
            blank_cnt  <= blank_cnt_nxt;
            decim_cnt  <= decim_cnt_nxt;
            Out_q      <= out_q_nxt;
            Out_i      <= out_i_nxt;
            out_valid  <= out_valid_nxt;
            switching  <= switching_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_PASS: begin
                if (sel_ch != sel_active)
                    state_nxt = ST_BLANK;
            end
            ST_BLANK: begin
                if (sel_ch == sel_pend && blank_cnt == '0)
                    state_nxt = ST_PASS;
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    // Output / datapath next values. A select change takes priority over a
    // coincident valid sample so no sample of the old source leaks out.
    always_comb begin
        sel_pend_nxt   = sel_pend;
        sel_active_nxt = sel_active;
        blank_cnt_nxt  = blank_cnt;
        decim_cnt_nxt  = decim_cnt;
        out_q_nxt      = Out_q;
        out_i_nxt      = Out_i;
        out_valid_nxt  = 1'b0;
        switching_nxt  = switching;
        case (state)
            ST_PASS: begin
                if (sel_ch != sel_active) begin
                    sel_pend_nxt  = sel_ch;
                    blank_cnt_nxt = BLANK_LAST;
                    out_q_nxt     = '0;
                    out_i_nxt     = '0;
                    switching_nxt = 1'b1;
                end else if (!sel_hit) begin
                    out_q_nxt = '0;
                    out_i_nxt = '0;
                end else if (sel_vld) begin
                    if (decim_cnt == '0) begin
                        out_q_nxt     = sel_word[DW-1:IQ_W];
                        out_i_nxt     = sel_word[IQ_W-1:0];
                        out_valid_nxt = 1'b1;
                        decim_cnt_nxt = decim;
                    end else begin
                        decim_cnt_nxt = decim_cnt - 1'b1;
                    end
                end
            end
            ST_BLANK: begin
                out_q_nxt     = '0;
                out_i_nxt     = '0;
                switching_nxt = 1'b1;
                if (sel_ch != sel_pend) begin
                    // Select moved again while blanking: restart the full window.
                    sel_pend_nxt  = sel_ch;
                    blank_cnt_nxt = BLANK_LAST;
                end else if (blank_cnt == '0) begin
                    sel_active_nxt = sel_pend;
                    decim_cnt_nxt  = '0;
                    switching_nxt  = 1'b0;
                end else begin
                    blank_cnt_nxt = blank_cnt - 1'b1;
                end
            end
            default: begin
                out_q_nxt = '0;
                out_i_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_iq_monitor_switch.sv
// Randomized self-checking bench for iq_monitor_switch against a behavioural model.
// Model: blanking lasts until BLANK_CYC consecutive edges see a steady select; decimation keeps every (decim+1)-th valid.
// Inputs are driven #1 after each rising edge; outputs are compared at the same point.
module tb_iq_monitor_switch;

    localparam int N_CH      = 17;
    localparam int IQ_W      = 16;
    localparam int SEL_W     = 8;
    localparam int BLANK_CYC = 4;
    localparam int DECIM_W   = 8;
    localparam int DW        = 2 * IQ_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH*DW-1:0]     ch_data;
    logic [N_CH-1:0]        ch_valid;
    logic [SEL_W-1:0]       sel_ch;
    logic [DECIM_W-1:0]     decim;
    logic [IQ_W-1:0]        Out_q;
    logic [IQ_W-1:0]        Out_i;
    logic                   out_valid;
    logic [SEL_W-1:0]       sel_active;
    logic                   switching;

    iq_monitor_switch #(
        .N_CH(N_CH), .IQ_W(IQ_W), .SEL_W(SEL_W),
        .BLANK_CYC(BLANK_CYC), .DECIM_W(DECIM_W)
    ) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid),
        .sel_ch(sel_ch), .decim(decim), .Out_q(Out_q), .Out_i(Out_i),
        .out_valid(out_valid), .sel_active(sel_active), .switching(switching)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model state.
    bit            m_blank;
    int            m_pend;
    int            m_quiet;   // consecutive blanking edges with an unchanged select
    int            m_act;
    int            m_k;       // valid samples seen since this pass period began
    logic [IQ_W-1:0] m_q, m_i;
    logic          m_ov;

    task automatic model_step();
        logic [DW-1:0] word;
        if (rst) begin
            m_blank = 1; m_pend = 0; m_quiet = 0; m_act = 0; m_k = 0;
            m_q = '0; m_i = '0; m_ov = 1'b0;
        end else if (m_blank) begin
            m_q = '0; m_i = '0; m_ov = 1'b0;
            if (int'(sel_ch) != m_pend) begin
                m_pend  = int'(sel_ch);
                m_quiet = 0;
            end else begin
                m_quiet++;
                if (m_quiet == BLANK_CYC) begin
                    m_blank = 0;
                    m_act   = m_pend;
                    m_k     = 0;
                end
            end
        end else begin
            m_ov = 1'b0;
            if (int'(sel_ch) != m_act) begin
                m_blank = 1; m_pend = int'(sel_ch); m_quiet = 0;
                m_q = '0; m_i = '0;
            end else if (m_act >= N_CH) begin
                m_q = '0; m_i = '0;
            end else if (ch_valid[m_act]) begin
                if (m_k % (int'(decim) + 1) == 0) begin
                    word = ch_data[m_act*DW +: DW];
                    m_q  = word[DW-1:IQ_W];
                    m_i  = word[IQ_W-1:0];
                    m_ov = 1'b1;
                end
                m_k++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check("out_q", Out_q, m_q);
        check("out_i", Out_i, m_i);
        check("out_valid", out_valid, m_ov);
        check("sel_active", sel_active, m_act[SEL_W-1:0]);
        check("switching", switching, m_blank);
    endtask

    task automatic rand_data();
        for (int w = 0; w < N_CH; w++)
            ch_data[w*DW +: DW] = $urandom();
    endtask

    initial begin
        int burst;
        int dens;
        logic [DW-1:0] w0;

        // Reset with channel 0 streaming a fixed word every cycle.
        rst      = 1'b1;
        sel_ch   = '0;
        decim    = '0;
        ch_valid = '1;
        ch_data  = '0;
        w0       = 32'h1234_ABCD;
        ch_data[DW-1:0] = w0;
        cycle();
        cycle();
        rst = 1'b0;
        for (int n = 0; n < 5; n++) cycle();
        check("first_q", Out_q, 16'h1234);
        check("first_i", Out_i, 16'hABCD);
        check("first_vld", out_valid, 1'b1);
        for (int n = 0; n < 3; n++) cycle();

        // Switch to channel 13 while it carries a fixed word.
        ch_data[13*DW +: DW] = 32'h0055_00AA;
        sel_ch = 8'd13;
        for (int n = 0; n < 6; n++) cycle();
        check("ch13_q", Out_q, 16'h0055);
        check("ch13_i", Out_i, 16'h00AA);
        check("ch13_sel", sel_active, 8'd13);

        // Randomized operation: select bursts, out-of-range selects,
        // decimation changes during blanking, occasional 1-cycle resets.
        burst = 0;
        dens  = 100;
        for (int n = 0; n < 6000; n++) begin
            if (n % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: dens = 100;
                    1: dens = 60;
                    default: dens = 25;
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            rand_data();
            for (int c = 0; c < N_CH; c++)
                ch_valid[c] = ($urandom_range(0, 99) < dens);
            if ($urandom_range(0, (burst > 0) ? 2 : 39) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    sel_ch = SEL_W'($urandom_range(N_CH, 255));
                else
                    sel_ch = SEL_W'($urandom_range(0, N_CH - 1));
                burst = 3;
            end else if (burst > 0) begin
                burst--;
            end
            if (m_blank && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 5) == 0)
                    decim = DECIM_W'($urandom_range(0, 255));
                else
                    decim = DECIM_W'($urandom_range(0, 3));
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
